// File: rtl/dtc_vote_pkg.sv
// ============================================================================
// Module   : dtc_vote_pkg
// Brief    : Shared class width, class count and FSM encoding for the vote window.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dtc_vote_pkg;

   localparam int CLASS_W     = 3;
   localparam int NUM_CLASSES = 8;

   typedef logic [CLASS_W-1:0] class_t;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCAN  = 2'd1,
      EMIT  = 2'd2
   } vote_state_t;

endpackage

`default_nettype wire

// File: rtl/dtc_vote_hist.sv
// ============================================================================
// Module   : dtc_vote_hist
// Brief    : Bank of per-class vote counters with a combinational read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtc_vote_hist
   import dtc_vote_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_en,
   input  class_t           inc_idx,
   input  logic             clr,
   input  class_t           rd_idx,
   output logic [CNT_W-1:0] rd_cnt
);

   logic [CNT_W-1:0] w_cnt [NUM_CLASSES];

   for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
         if (rst || clr) begin
            r_cnt <= '0;
         end else if (inc_en && (inc_idx == class_t'(g))) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      assign w_cnt[g] = r_cnt;
   end

   assign rd_cnt = w_cnt[rd_idx];

endmodule

`default_nettype wire

// File: rtl/dtc_vote_window.sv
// ============================================================================
// Module   : dtc_vote_window
// Brief    : Majority vote of classifier labels over a WINDOW-sample window.
//            Define DTC_VOTE_CONF_EN to add the out_confident flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtc_vote_window
   import dtc_vote_pkg::*;
#(
   parameter int WINDOW      = 16,
   parameter int CNT_W       = $clog2(WINDOW + 1),
   parameter int CONF_THRESH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_class,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_class,
   output logic [CNT_W-1:0] out_count
`ifdef DTC_VOTE_CONF_EN
   ,
   output logic             out_confident
`endif
);

   localparam logic [CNT_W-1:0] c_last_samp = CNT_W'(WINDOW - 1);
   localparam class_t           c_last_cls  = class_t'(NUM_CLASSES - 1);

   vote_state_t      r_state;
   logic [CNT_W-1:0] r_samp_cnt;
   logic [CNT_W-1:0] r_best_cnt;
   class_t           r_best_class;
   class_t           r_scan_idx;

   logic             w_accept;
   logic             w_clr;
   logic [CNT_W-1:0] w_rd_cnt;

   assign in_ready = (r_state == ACCUM);
   assign w_accept = in_valid && in_ready;
   assign w_clr    = out_valid && out_ready;

   dtc_vote_hist #(
      .CNT_W (CNT_W)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .inc_en  (w_accept),
      .inc_idx (in_class),
      .clr     (w_clr),
      .rd_idx  (r_scan_idx),
      .rd_cnt  (w_rd_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ACCUM;
         r_samp_cnt    <= '0;
         r_best_cnt    <= '0;
         r_best_class  <= '0;
         r_scan_idx    <= '0;
         out_valid     <= 1'b0;
         out_class     <= '0;
         out_count     <= '0;
`ifdef DTC_VOTE_CONF_EN
         out_confident <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_samp_cnt <= r_samp_cnt + CNT_W'(1);
                  if (r_samp_cnt == c_last_samp) begin
                     r_state      <= SCAN;
                     r_scan_idx   <= '0;
                     r_best_cnt   <= '0;
                     r_best_class <= '0;
                  end
               end
            end
            SCAN: begin
               // Strict compare keeps the lowest index on a tie.
               if (w_rd_cnt > r_best_cnt) begin
                  r_best_cnt   <= w_rd_cnt;
                  r_best_class <= r_scan_idx;
               end
               r_scan_idx <= r_scan_idx + class_t'(1);
               if (r_scan_idx == c_last_cls) begin
                  r_state <= EMIT;
               end
            end
            EMIT: begin
               // First EMIT cycle loads the result; it then holds until accepted.
               if (!out_valid) begin
                  out_valid     <= 1'b1;
                  out_class     <= r_best_class;
                  out_count     <= r_best_cnt;
`ifdef DTC_VOTE_CONF_EN
                  out_confident <= (32'(r_best_cnt) >= 32'(CONF_THRESH));
`endif
               end else if (out_ready) begin
                  out_valid  <= 1'b0;
                  r_samp_cnt <= '0;
                  r_state    <= ACCUM;
               end
            end
            default: begin
               r_state <= ACCUM;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dtc_vote_window.sv
// ============================================================================
// Module   : tb_dtc_vote_window
// Brief    : Directed and randomized self-checking bench for dtc_vote_window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dtc_vote_window;

   localparam int WINDOW = 16;
   localparam int CNT_W  = 5;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             in_valid  = 1'b0;
   logic [2:0]       in_class  = 3'd0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [2:0]       out_class;
   logic [CNT_W-1:0] out_count;
`ifdef DTC_VOTE_CONF_EN
   logic             out_confident;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   dtc_vote_window #(
      .WINDOW      (WINDOW),
      .CONF_THRESH (12)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_class      (in_class),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_class     (out_class),
      .out_count     (out_count)
`ifdef DTC_VOTE_CONF_EN
      ,
      .out_confident (out_confident)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called #1 after an edge; returns #1 after the edge that accepted the sample.
   task automatic send(input logic [2:0] c);
      int guard = 0;
      in_valid = 1'b1;
      in_class = c;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) chk("send_timeout", 32'(guard), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_n(input logic [2:0] c, input int n);
      for (int i = 0; i < n; i++) send(c);
   endtask

   task automatic wait_result(input string tag, input int ec, input int en, input int elat);
      int lat = 0;
      while (!out_valid && lat < 100) begin
         chk({tag, "_busy_in_ready"}, 32'(in_ready), 0);
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 1);
      if (elat > 0) chk({tag, "_latency"}, 32'(lat), 32'(elat));
      chk({tag, "_class"}, 32'(out_class), 32'(ec));
      chk({tag, "_count"}, 32'(out_count), 32'(en));
`ifdef DTC_VOTE_CONF_EN
      chk({tag, "_conf"}, 32'(out_confident), (en >= 12) ? 32'd1 : 32'd0);
`endif
   endtask

   task automatic accept(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_clr"}, 32'(out_valid), 0);
      chk({tag, "_ready_back"}, 32'(in_ready), 1);
   endtask

   initial begin
      int h [8];
      int best;
      int bc;
      logic [2:0] c;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_class", 32'(out_class), 0);
      chk("rst_out_count", 32'(out_count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      send_n(3'd5, 10);
      send_n(3'd2, 6);
      wait_result("maj", 5, 10, 9);
      accept("maj");

      send_n(3'd3, 8);
      send_n(3'd1, 8);
      wait_result("tie", 1, 8, 9);
      accept("tie");

      send_n(3'd6, 9);
      send_n(3'd0, 7);
      wait_result("stall", 6, 9, 9);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_class", 32'(out_class), 6);
         chk("stall_count", 32'(out_count), 9);
         chk("stall_in_ready", 32'(in_ready), 0);
      end
      accept("stall");
      send_n(3'd7, 16);
      wait_result("after_stall", 7, 16, 9);
      accept("after_stall");

      send_n(3'd4, 7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_out_valid", 32'(out_valid), 0);
      send_n(3'd6, 16);
      wait_result("midrst", 6, 16, 9);
      accept("midrst");

`ifdef DTC_VOTE_CONF_EN
      send_n(3'd0, 12);
      send_n(3'd1, 4);
      wait_result("conf_hi", 0, 12, 9);
      accept("conf_hi");
      send_n(3'd0, 11);
      send_n(3'd1, 5);
      wait_result("conf_lo", 0, 11, 9);
      accept("conf_lo");
`endif

      for (int w = 0; w < 200; w++) begin
         for (int k = 0; k < 8; k++) h[k] = 0;
         for (int s = 0; s < WINDOW; s++) begin
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
            end
            c = 3'($urandom_range(0, 7));
            h[c]++;
            send(c);
         end
         best = 0;
         bc   = 0;
         for (int k = 0; k < 8; k++) begin
            if (h[k] > best) begin
               best = h[k];
               bc   = k;
            end
         end
         wait_result("rand", bc, best, 9);
         accept("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dtc_vote_window.md
Name: dtc_vote_window

Overview:
- Downstream consumer of the split-0.875 decision-tree classifier (12-bit feature in, 3-bit class out).
- Accepts a stream of per-sample class labels over valid/ready and histograms them over a fixed window of WINDOW samples.
- Emits the majority (argmax) class and its vote count once per window, smoothing single-sample misclassifications before downstream decision logic.

Parameters:
- WINDOW, 16: samples per voting window; legal range 1..255.
- CNT_W, $clog2(WINDOW+1): per-class counter width; derived, not overridden.
- CONF_THRESH, 12: minimum winning count for out_confident; used only with DTC_VOTE_CONF_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_class holds a classifier result.
- in_ready  output  1  block accepts a sample this cycle.
- in_class  input  3  class label 0..7 from the classifier outp.
- out_valid  output  1  result held stable until accepted.
- out_ready  input  1  downstream accepts the result.
- out_class  output  3  winning class.
- out_count  output  CNT_W  votes for the winning class.
- out_confident  output  1  present only when DTC_VOTE_CONF_EN is defined.

Behaviour:
- Reset values (rst sampled high at an edge):
  - state = ACCUM; all 8 counters = 0; sample counter = 0.
  - out_valid = 0; out_class = 0; out_count = 0; out_confident = 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-window or mid-scan discards all partial state; no output is produced for that window.
- FSM states: ACCUM, SCAN, EMIT.
- ACCUM:
  - in_ready = 1.
  - On in_valid && in_ready: increment counter[in_class] and the sample counter.
  - On the WINDOW-th accepted sample, go to SCAN. The counter update for that sample lands at the same edge.
- SCAN:
  - in_ready = 0.
  - Visits classes 0..7, one per cycle, so the state lasts exactly 8 cycles.
  - Running best is replaced only if count > best (strictly greater), so ties resolve to the lowest class index.
  - After index 7, go to EMIT.
- EMIT:
  - in_ready = 0; out_valid = 1; out_class and out_count are registered and stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear all counters and the sample counter, deassert out_valid, go to ACCUM. in_ready rises the next cycle.
- Latency: out_valid rises at the 9th rising edge after the edge that accepts the final sample of a window.
- Throughput: one sample per cycle in ACCUM; a window occupies at least WINDOW + 9 cycles.
- Counters cannot overflow: at most WINDOW increments per window, and CNT_W covers WINDOW.
- Stalls:
  - in_valid low in ACCUM simply stalls accumulation.
  - No samples are accepted in SCAN or EMIT; upstream must hold its data.
- WINDOW = 1: out_class equals the single accepted label and out_count = 1.
- Classes with zero votes are legal candidates. An all-zero histogram cannot occur because WINDOW ≥ 1.

Optional Feature:
- Macro: DTC_VOTE_CONF_EN.
- Defined:
  - Adds the out_confident port.
  - out_confident = (winning count ≥ CONF_THRESH); it is registered alongside out_class and valid only while out_valid is high.
  - Reset value 0.
- Undefined:
  - Port absent; no comparator is synthesized.
  - All other behaviour is identical.

Decomposition:
- Package dtc_vote_pkg:
  - CLASS_W = 3 and NUM_CLASSES = 8.
  - typedef class_t as logic [CLASS_W-1:0].
  - FSM enum vote_state_t {ACCUM, SCAN, EMIT}.
- Sub-module dtc_vote_hist, the counter bank:
  - 8 × CNT_W registers.
  - Inputs: inc_en, inc_idx, clr.
  - Combinational read port rd_idx/rd_cnt, used by the SCAN loop.
  - inc and clr are never asserted together.
- The top level holds the FSM, sample counter, argmax registers and handshakes.

Test Plan:
- WINDOW=16; send 10×class 5 and 6×class 2 back-to-back; out_ready=1 → out_class=5, out_count=10; out_valid rises 9 cycles after the last accept.
- WINDOW=16; send 8×class 3 then 8×class 1 (tie) → out_class=1, out_count=8 (lowest index wins).
- Hold out_ready=0 for 20 cycles in EMIT → out_valid, out_class and out_count stable; in_ready=0 throughout; the following window starts with cleared counters, checked by a second window of 16×class 7 → out_class=7, out_count=16.
- Assert rst after 7 samples of class 4, then send a full window of 16×class 6 → out_class=6, out_count=16 (pre-reset votes are discarded).
- Random in_valid gaps (~50% duty) with a scoreboard comparing against a reference histogram over 200 windows → every result matches; no sample lost or double-counted.
- DTC_VOTE_CONF_EN, CONF_THRESH=12: 12×class 0 + 4×class 1 → out_confident=1; 11×class 0 + 5×class 1 → out_confident=0.
